// File: rtl/riscv_pkg.sv
// Shared types and constants for the core-side memory path.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_IF   = 2'd1,
        WIN_D    = 2'd2
    } winner_t;

    // Opcodes used by the core-side glue that derives d_we.
    localparam logic [6:0]  LW  = 7'b000_0011;
    localparam logic [6:0]  SW  = 7'b010_0011;
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Priority decision between fetch and data; data wins unless fetch has been starved.
module arb_prio
    import riscv_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output winner_t          winner
);

    always_comb begin
        winner = WIN_NONE;
        if (if_req && d_req) begin
            winner = (starve_cnt == CNT_W'(STARVE_MAX)) ? WIN_IF : WIN_D;
        end else if (if_req) begin
            winner = WIN_IF;
        end else if (d_req) begin
            winner = WIN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store,
// one transaction outstanding at a time.
//
// state   | meaning
// IDLE    | no access in flight; arbitration and grant happen here
// BUSY_IF | fetch access in flight, waiting for mem_ack
// BUSY_D  | load/store access in flight, waiting for mem_ack
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    state_t           state;
    state_t           state_next;
    winner_t          winner;
    logic [CNT_W-1:0] starve_cnt;

    arb_prio #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_arb_prio (
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .winner     (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (winner == WIN_IF)     state_next = BUSY_IF;
                else if (winner == WIN_D) state_next = BUSY_D;
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Grants depend only on requests and registered state, never on mem_ack.
    always_comb begin
        if_gnt  = (state == IDLE) && (winner == WIN_IF);
        d_gnt   = (state == IDLE) && (winner == WIN_D);
        mem_req = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (if_gnt) begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
        end else if (d_gnt) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (mem_ack && state == BUSY_IF) begin
                if_rvalid <= 1'b1;
                if_rdata  <= mem_rdata;
            end
            if (mem_ack && state == BUSY_D) begin
                d_rvalid <= 1'b1;
                d_rdata  <= mem_we ? '0 : mem_rdata;
            end
        end
    end

    // Counts contested data wins; saturates so fetch keeps priority until served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && if_req && starve_cnt != CNT_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, corner sequences and random traffic
// checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory environment: acks after a chosen latency counted from the first mem_req cycle.
    logic [31:0] mem_arr [logic [31:0]];
    bit  rand_lat  = 1'b0;
    int  fixed_lat = 1;
    bit  force_ack = 1'b0;
    int  busy_cyc  = 0;
    int  cur_lat   = 1;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (busy_cyc == 0) cur_lat = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
                busy_cyc++;
                if (busy_cyc == cur_lat) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_rdata = $urandom;
                        mem_arr[mem_addr] = mem_wdata;
                    end else begin
                        mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
                    end
                    busy_cyc = 0;
                end
            end else begin
                busy_cyc = 0;
            end
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Transaction-level reference model.
    logic [31:0] ref_mem [logic [31:0]];
    bit          m_busy = 0, m_owner_d = 0, m_we = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_exp = '0;
    int          m_starve = 0;
    bit          rv_pend = 0, rv_owner_d = 0;
    logic [31:0] rv_exp = '0, last_if = '0, last_d = '0;
    bit          hold_reqs = 0;
    bit          s_if_gnt, s_d_gnt, s_if_rv, s_d_rv;
    logic [31:0] s_if_rdata, s_d_rdata;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic model_reset();
        m_busy = 0; rv_pend = 0; m_starve = 0; last_if = '0; last_d = '0;
    endtask

    // Entered at posedge+1 after inputs are driven; returns at the next posedge+1.
    task automatic tick();
        bit eif, ed;
        #2;
        eif = !m_busy && if_req && (!d_req || m_starve >= STARVE_MAX);
        ed  = !m_busy && d_req && !eif;
        s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_if_rv = if_rvalid; s_d_rv = d_rvalid;
        s_if_rdata = if_rdata; s_d_rdata = d_rdata;
        chk("if_gnt", if_gnt, eif);
        chk("d_gnt", d_gnt, ed);
        chk("mem_req", mem_req, m_busy);
        if (m_busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_rvalid", if_rvalid, rv_pend && !rv_owner_d);
        chk("d_rvalid", d_rvalid, rv_pend && rv_owner_d);
        if (rv_pend) begin
            if (rv_owner_d) last_d = rv_exp;
            else            last_if = rv_exp;
        end
        chk("if_rdata", if_rdata, last_if);
        chk("d_rdata", d_rdata, last_d);
        rv_pend    = m_busy && mem_ack;
        rv_owner_d = m_owner_d;
        rv_exp     = m_exp;
        if (m_busy) begin
            if (mem_ack) m_busy = 0;
        end else if (eif) begin
            m_busy = 1; m_owner_d = 0; m_we = 0; m_addr = if_addr; m_wdata = '0;
            m_exp = ref_rd(if_addr);
            m_starve = 0;
        end else if (ed) begin
            m_busy = 1; m_owner_d = 1; m_we = d_we; m_addr = d_addr;
            m_wdata = d_wdata;
            m_exp = d_we ? 32'h0 : ref_rd(d_addr);
            if (d_we) ref_mem[d_addr] = d_wdata;
            if (if_req && m_starve < STARVE_MAX) m_starve++;
        end
        @(posedge clk);
        #1;
        if (eif && !hold_reqs) if_req = 1'b0;
        if (ed && !hold_reqs)  d_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && (m_busy || rv_pend); i++) tick();
        chk("drain_idle", {31'b0, m_busy || rv_pend}, 32'h0);
    endtask

    typedef struct {
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic run_vec(input vec_t v);
        bit seen = 0;
        fixed_lat = v.lat;
        if (v.fetch) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end
        tick();
        chk("vec_gnt", v.fetch ? s_if_gnt : s_d_gnt, 32'h1);
        for (int c = 1; c <= 10 && !seen; c++) begin
            tick();
            if (v.fetch ? s_if_rv : s_d_rv) begin
                seen = 1;
                chk("vec_latency", c, v.lat + 1);
                chk("vec_rdata", v.fetch ? s_if_rdata : s_d_rdata, v.exp_rdata);
            end
        end
        chk("vec_rvalid_seen", {31'b0, seen}, 32'h1);
        tick();
    endtask

    vec_t vecs [5];
    bit   exp_pat [11];
    int   k;

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_arr[32'h10] = 32'h0000_0013; ref_mem[32'h10] = 32'h0000_0013;
        mem_arr[32'h40] = 32'h1234_5678; ref_mem[32'h40] = 32'h1234_5678;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        rst_n = 1'b1;

        vecs[0] = '{fetch: 1, we: 0, addr: 32'h10, wdata: 32'h0, lat: 1, exp_rdata: 32'h0000_0013};
        vecs[1] = '{fetch: 0, we: 0, addr: 32'h40, wdata: 32'h0, lat: 3, exp_rdata: 32'h1234_5678};
        vecs[2] = '{fetch: 0, we: 1, addr: 32'h44, wdata: 32'hDEAD_BEEF, lat: 2, exp_rdata: 32'h0};
        vecs[3] = '{fetch: 0, we: 0, addr: 32'h44, wdata: 32'h0, lat: 1, exp_rdata: 32'hDEAD_BEEF};
        vecs[4] = '{fetch: 1, we: 0, addr: 32'h44, wdata: 32'h0, lat: 2, exp_rdata: 32'hDEAD_BEEF};
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Contention: four data wins, one forced fetch, then data again.
        exp_pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        hold_reqs = 1; fixed_lat = 1;
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h84;
        k = 0;
        for (int c = 0; c < 80 && k < 11; c++) begin
            tick();
            if (s_if_gnt || s_d_gnt) begin
                chk("contend_data_wins", {31'b0, s_d_gnt}, {31'b0, exp_pat[k]});
                k++;
            end
        end
        chk("contend_grants", k, 11);
        hold_reqs = 0; if_req = 0; d_req = 0;
        drain();

        // Reset in the middle of a slow load.
        fixed_lat = 5;
        d_req = 1; d_we = 0; d_addr = 32'h40;
        tick();
        chk("rstmid_gnt", s_d_gnt, 1);
        tick();
        tick();
        rst_n = 1'b0;
        d_req = 0;
        #1;
        chk("rstmid_mem_req", mem_req, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        chk("rstmid_d_rvalid", d_rvalid, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rstmid_no_rvalid", {30'b0, s_if_rv, s_d_rv}, 0);
        end
        fixed_lat = 1;
        if_req = 1; if_addr = 32'h10;
        tick();
        chk("post_reset_gnt", s_if_gnt, 1);
        drain();

        // Spurious ack while idle.
        force_ack = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("spur_no_rvalid", {30'b0, s_if_rv, s_d_rv}, 0);
        end
        force_ack = 0;
        tick();
        chk("spur_no_rvalid_after", {30'b0, s_if_rv, s_d_rv}, 0);
        d_req = 1; d_we = 0; d_addr = 32'h40;
        tick();
        chk("spur_then_gnt", s_d_gnt, 1);
        drain();

        // Random traffic with random memory latency.
        rand_lat = 1;
        for (int c = 0; c < 1500; c++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = 32'h100 + 4 * $urandom_range(0, 7);
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = $urandom_range(0, 1) == 1;
                d_addr = 32'h100 + 4 * $urandom_range(0, 7);
                d_wdata = $urandom;
            end
            tick();
        end
        if_req = 0; d_req = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, variable-latency memory between the pipelined RISC-V core's instruction-fetch stage and its MEM stage (load/store). One transaction is outstanding at a time. Data accesses normally win, and a starvation counter guarantees fetch progress. The block sits between the core's IF/MEM stages and the unified memory model, replacing the separate instruction and data arrays.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- STARVE_MAX, 4, consecutive contested data grants before fetch is forced to win (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store (SW), 0 = load (LW)
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse; load data valid or store complete
- d_rdata  out  DATA_W  load data (0 for stores)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory byte address, passed unmodified
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D. Arbitration happens only in IDLE.
- IDLE, only if_req: if_gnt=1 (combinational), go to BUSY_IF.
- IDLE, only d_req: d_gnt=1, go to BUSY_D.
- IDLE, both requesting: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
- Neither requesting: stay in IDLE.
- On grant: register mem_addr, mem_we (0 for fetch), and mem_wdata from the winner. mem_req is high from the next cycle.
- BUSY_*: hold mem_req and all mem_* outputs stable until mem_ack.
- On mem_ack: capture mem_rdata (0 for a store), drop mem_req, go to IDLE. Pulse the owner's *_rvalid with registered data in the next cycle.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - increments, saturating, on a data grant while if_req=1;
  - clears on any fetch grant;
  - unchanged otherwise.
- The loser of a contested grant sees *_gnt=0 and must keep its request asserted. No request is queued internally.
- mem_ack outside BUSY_* is ignored. *_rvalid never asserts without a prior grant.

## Timing
- Reset (async assert, synchronous deassert use): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; all gnt/rvalid=0; if_rdata=d_rdata=0; starve_cnt=0.
- Reset mid-transaction abandons the memory access. No rvalid is produced for it.
- Grant at cycle t → mem_req=1 at t+1 → mem_ack at t+k (k≥1) → rvalid at t+k+1.
- The state is IDLE at t+k+1, so a new grant may occur in the same cycle as rvalid.
- Minimum latency is request-to-rvalid 2 cycles. Peak throughput is one transaction per 2 cycles.
- *_gnt is combinational from *_req and registered state only. It does not depend on mem_ack (no combinational mem→core path).
- *_rdata holds its last value until the next rvalid for that port.

## Structure
- Shared package riscv_pkg:
  - state enum {IDLE, BUSY_IF, BUSY_D};
  - opcode constants LW=7'b000_0011, SW=7'b010_0011, NOP=32'h0000_0013 (used by core-side glue that drives d_we).
- Single module. The starvation counter and priority decision may be factored into arb_prio (inputs if_req, d_req, starve_cnt; output winner). No other sub-module.

## Test plan
- Fetch only: if_addr=0x10 held, memory acks 1 cycle after mem_req with 0x00000013 → if_gnt at t, mem_addr=0x10 at t+1, if_rvalid with if_rdata=0x00000013 at t+2.
- Load with 3-cycle latency: d_req, d_we=0, d_addr=0x40 → mem_req high for 3 cycles, mem_addr stable; d_rvalid with mem_rdata value 1 cycle after ack.
- Store: d_we=1, d_addr=0x44, d_wdata=0xDEADBEEF → mem_we=1, mem_wdata=0xDEADBEEF until ack; d_rvalid pulse with d_rdata=0.
- Contention, STARVE_MAX=4: if_req and d_req held continuously → data granted 4 times, then 1 fetch grant, then data again; starve_cnt is 0 after the fetch grant.
- Reset mid-op: assert rst_n=0 while BUSY_D with ack pending → mem_req=0 immediately (async); no d_rvalid after release; first post-reset request is granted from IDLE.
- Spurious ack: mem_ack=1 in IDLE with no requests → no rvalid, state stays IDLE.
